arb_mux4: RTL and testbench

ARB_MUX4 -- requirements
Module: arb_mux4

---
 rtl/arb_mux4_if.sv | 29 ++
 rtl/arb_mux4.sv | 65 ++++++
 tb/tb_arb_mux4.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/arb_mux4_if.sv
// arb_mux4_if: channel/output bundle for arb_mux4; in_last exists only with ARB_MUX4_LOCK_EN.
interface arb_mux4_if #(parameter int WIDTH = 8);
    logic             mode;
    logic [1:0]       sel;
    logic [WIDTH-1:0] A, B, C, D;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
`ifdef ARB_MUX4_LOCK_EN
    logic [3:0]       in_last;
`endif
    logic [WIDTH-1:0] OUT;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_sel;
    modport slave (
`ifdef ARB_MUX4_LOCK_EN
        input in_last,
`endif
        input mode, sel, A, B, C, D, in_valid, out_ready,
        output in_ready, OUT, out_valid, out_sel
    );
    modport master (
`ifdef ARB_MUX4_LOCK_EN
        output in_last,
`endif
        output mode, sel, A, B, C, D, in_valid, out_ready,
        input in_ready, OUT, out_valid, out_sel
    );
endinterface

// File: rtl/arb_mux4.sv
// arb_mux4: 4-channel round-robin/fixed-select arbiter into a one-word output register.
// Optional packet lock enabled by defining ARB_MUX4_LOCK_EN.
module arb_mux4 #(
    parameter int         WIDTH   = 8,
    parameter logic [1:0] RR_INIT = 2'd3
) (
    input  logic        clk,
    input  logic        rst,
    arb_mux4_if.slave   bus
);
    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    logic [1:0]       r_sel;
    logic [1:0]       r_ptr;
    logic             w_load_en;
    logic [1:0]       w_rr_gnt;
    logic [1:0]       w_gnt;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;
`ifdef ARB_MUX4_LOCK_EN
    logic             r_locked;
    logic [1:0]       r_lock_ch;
`endif
    assign w_load_en = !r_valid || bus.out_ready;
    // Scan farthest-first so the nearest valid channel after r_ptr wins; none valid -> r_ptr+1.
    always_comb begin
        w_rr_gnt = r_ptr + 2'd1;
        for (int k = 3; k >= 0; k--)
            if (bus.in_valid[r_ptr + 2'(k + 1)]) w_rr_gnt = r_ptr + 2'(k + 1);
    end
`ifdef ARB_MUX4_LOCK_EN
    assign w_gnt = r_locked ? r_lock_ch : bus.mode ? bus.sel : w_rr_gnt;
`else
    assign w_gnt = bus.mode ? bus.sel : w_rr_gnt;
`endif
    assign w_data = w_gnt == 2'd0 ? bus.A : w_gnt == 2'd1 ? bus.B : w_gnt == 2'd2 ? bus.C : bus.D;
    assign w_xfer = !rst && w_load_en && bus.in_valid[w_gnt];
    assign bus.in_ready  = (w_load_en && !rst) ? 4'b0001 << w_gnt : 4'b0000;
    assign bus.OUT       = r_out;
    assign bus.out_valid = r_valid;
    assign bus.out_sel   = r_sel;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_sel   <= 2'd0;
            r_ptr   <= RR_INIT;
`ifdef ARB_MUX4_LOCK_EN
            r_locked  <= 1'b0;
            r_lock_ch <= 2'd0;
`endif
        end else if (w_load_en) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_out <= w_data;
                r_sel <= w_gnt;
                r_ptr <= w_gnt;
`ifdef ARB_MUX4_LOCK_EN
                r_locked  <= !bus.in_last[w_gnt];
                r_lock_ch <= w_gnt;
`endif
            end
        end
    end
endmodule

// File: tb/tb_arb_mux4.sv
// tb_arb_mux4: directed + random checks of arb_mux4 against a behavioural model.
module tb_arb_mux4;
    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad = 0;
    logic       m_valid;
    logic [7:0] m_out;
    logic [1:0] m_sel;
    int         m_ptr;
    logic       m_lock;
    int         m_lock_ch;
    arb_mux4_if #(.WIDTH(8)) bus ();
    arb_mux4 #(.WIDTH(8), .RR_INIT(2'd3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    function automatic int m_grant();
        if (m_lock) return m_lock_ch;
        if (bus.mode) return int'(bus.sel);
        for (int k = 1; k <= 4; k++)
            if (bus.in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return (m_ptr + 1) % 4;
    endfunction
    function automatic logic [7:0] m_data(int g);
        return g == 0 ? bus.A : g == 1 ? bus.B : g == 2 ? bus.C : bus.D;
    endfunction
    task automatic cycle();
        logic ld, x, last;
        int g;
        logic [3:0] er;
        #1;
        ld = !m_valid || bus.out_ready;
        g = m_grant();
        x = !rst && ld && bus.in_valid[g];
        er = (rst || !ld) ? 4'b0000 : 4'b0001 << g;
`ifdef ARB_MUX4_LOCK_EN
        last = bus.in_last[g];
`else
        last = 1'b1;
`endif
        if (!rst && ld && !m_lock && !bus.mode && bus.in_valid == 4'b0000)
            chk("rdy_idle", 32'($onehot(bus.in_ready)), 32'd1);
        else
            chk("in_ready", 32'(bus.in_ready), 32'(er));
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_out = 0; m_sel = 0; m_ptr = 3; m_lock = 0; m_lock_ch = 0;
        end else if (ld) begin
            m_valid = x;
            if (x) begin
                m_out = m_data(g);
                m_sel = 2'(g);
                m_ptr = g;
`ifdef ARB_MUX4_LOCK_EN
                m_lock = !last;
                m_lock_ch = g;
`endif
            end
        end
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("OUT", 32'(bus.OUT), 32'(m_out));
        chk("out_sel", 32'(bus.out_sel), 32'(m_sel));
    endtask
    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask
    initial begin
        m_valid = 0; m_out = 0; m_sel = 0; m_ptr = 3; m_lock = 0; m_lock_ch = 0;
        rst = 1'b1;
        bus.mode = 1'b0; bus.sel = 2'd0; bus.out_ready = 1'b1; bus.in_valid = 4'b1111;
        bus.A = 8'h11; bus.B = 8'h22; bus.C = 8'h33; bus.D = 8'h44;
`ifdef ARB_MUX4_LOCK_EN
        bus.in_last = 4'b1111;
`endif
        repeat (2) cycle();
        chk("rst_ov", 32'(bus.out_valid), 32'd0);
        chk("rst_out", 32'(bus.OUT), 32'd0);
        chk("rst_rdy", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        // round robin
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_sel", 32'(bus.out_sel), 32'(k % 4));
            chk("rr_out", 32'(bus.OUT), 32'(8'h11 * (k % 4 + 1)));
        end
        // backpressure
        do_reset();
        cycle();
        chk("bp_first", 32'(bus.OUT), 32'h11);
        bus.out_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("bp_hold", 32'(bus.OUT), 32'h11);
            chk("bp_rdy", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_next", 32'(bus.OUT), 32'h22);
        chk("bp_ov", 32'(bus.out_valid), 32'd1);
        // fixed select
        bus.mode = 1'b1; bus.sel = 2'd2; bus.C = 8'h5A;
        repeat (3) begin
            cycle();
            chk("fx_out", 32'(bus.OUT), 32'h5A);
            chk("fx_sel", 32'(bus.out_sel), 32'd2);
            #1 chk("fx_rdy", 32'(bus.in_ready), 32'b0100);
        end
        // sparse with ptr=0
        bus.mode = 1'b0;
        do_reset();
        cycle();
        bus.in_valid = 4'b1001;
        cycle();
        chk("sp_d", 32'(bus.out_sel), 32'd3);
        cycle();
        chk("sp_a", 32'(bus.out_sel), 32'd0);
        bus.in_valid = 4'b0000;
        cycle();
        chk("sp_idle", 32'(bus.out_valid), 32'd0);
`ifdef ARB_MUX4_LOCK_EN
        do_reset();
        bus.in_valid = 4'b1111;
        cycle();
        bus.in_last = 4'b1101;
        cycle();
        chk("lk_b0", 32'(bus.out_sel), 32'd1);
        cycle();
        chk("lk_b1", 32'(bus.out_sel), 32'd1);
        bus.in_last = 4'b1111;
        cycle();
        chk("lk_b2", 32'(bus.out_sel), 32'd1);
        cycle();
        chk("lk_c", 32'(bus.out_sel), 32'd2);
`endif
        // random
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus.mode = ($urandom_range(0, 3) == 0);
            bus.sel = 2'($urandom);
            bus.in_valid = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.A = 8'($urandom); bus.B = 8'($urandom);
            bus.C = 8'($urandom); bus.D = 8'($urandom);
`ifdef ARB_MUX4_LOCK_EN
            bus.in_last = 4'($urandom);
`endif
            cycle();
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
